data_sync_src: RTL and testbench

Source-domain launcher that feeds the destination-domain bus synchronizer (`DATA_SYNC`). It accepts words from local logic over a valid/ready handshake and drives a stable `unsync_bus` plus a `bus_enable` level whose rising edge the destination detects. It keeps the bus frozen until the transfer is provably captured: either by acknowledge feedback or by a fixed hold time. It sits in the source clock domain at every CDC crossing that uses `DATA_SYNC`.

---
 rtl/data_sync_pkg.sv | 13 +
 rtl/data_sync_src_bit_sync.sv | 20 ++
 rtl/data_sync_src.sv | 122 ++++++++++++
 tb/tb_data_sync_src.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sync_pkg.sv
// Shared types and limits for the source-side launcher of the DATA_SYNC bus crossing.
package data_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } sync_state_t;

  localparam int MIN_NUM_STAGES  = 2;
  localparam int MIN_HOLD_CYCLES = 1;

endpackage

// File: rtl/data_sync_src_bit_sync.sv
// Generic NUM_STAGES-flop single-bit synchronizer, async active-high reset to 0.
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[NUM_STAGES-2:0], d};
  end

  assign q = ff[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_src.sv
// Source-domain launcher for DATA_SYNC: holds unsync_bus stable around a bus_enable level.
// Closed-loop acknowledge handshake when DATA_SYNC_SRC_ACK_EN is defined, fixed hold otherwise.
module data_sync_src
  import data_sync_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_STAGES  = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] unsync_bus,
  output logic                  bus_enable,
  input  logic                  ack_async,
  output logic                  busy,
  output logic                  done_pulse,
  output sync_state_t           state_dbg
);

  // Handshake: a word moves on a clk edge where in_valid && in_ready; in_ready is
  // registered and high only in IDLE, so the producer must hold in_data until then.
  sync_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] bus_next;
  logic                  en_next, busy_next, ready_next, done_next;
  logic                  phase_done;
  logic                  unused_cfg;

`ifdef DATA_SYNC_SRC_ACK_EN
  localparam int STAGES = (NUM_STAGES < MIN_NUM_STAGES) ? MIN_NUM_STAGES : NUM_STAGES;

  logic ack_sync;

  bit_sync #(.NUM_STAGES(STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_async),
    .q   (ack_sync)
  );

  // Four-phase: ASSERT waits for ack high, RELEASE waits for ack low, no timeout.
  assign phase_done = (state == ST_ASSERT) ? ack_sync : ~ack_sync;
  assign unused_cfg = (HOLD_CYCLES > 0);
`else
  localparam int HOLD = (HOLD_CYCLES < MIN_HOLD_CYCLES) ? MIN_HOLD_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] hold_cnt;

  // Counter restarts on every state entry so each phase lasts exactly HOLD cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      hold_cnt <= '0;
    else if (state_next != state) hold_cnt <= '0;
    else if (state != ST_IDLE)    hold_cnt <= hold_cnt + 1'b1;
  end

  assign phase_done = (hold_cnt == LAST);
  assign unused_cfg = ack_async ^ (NUM_STAGES > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      unsync_bus <= bus_next;
      bus_enable <= en_next;
      in_ready   <= ready_next;
      busy       <= busy_next;
      done_pulse <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    bus_next   = unsync_bus;
    en_next    = bus_enable;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_next = ST_ASSERT;
          bus_next   = in_data;
          en_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (phase_done) begin
          state_next = ST_RELEASE;
          en_next    = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (phase_done) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        en_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
    // in_ready stays 0 through the first edge after reset, then tracks IDLE.
    ready_next = (state_next == ST_IDLE);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_data_sync_src.sv
// Self-checking bench for data_sync_src; open-loop by default, ack tests with DATA_SYNC_SRC_ACK_EN.
module tb_data_sync_src;
  import data_sync_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int H2 = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic dst_clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  initial begin
    #2;
    forever #15 dst_clk = ~dst_clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT under direct test ----------------
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         ack_main = 1'b0;
  logic         in_ready, bus_enable, busy, done_pulse;
  logic [W-1:0] unsync_bus;
  sync_state_t  st_main;

  data_sync_src #(.DATA_WIDTH(W), .NUM_STAGES(2), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .ack_async(ack_main),
    .busy(busy), .done_pulse(done_pulse), .state_dbg(st_main)
  );

  // ---------------- end-to-end DUT with destination model ----------------
  logic [W-1:0] in_data2 = '0;
  logic         in_valid2 = 1'b0;
  logic         in_ready2, en2, busy2, done2, ack2;
  logic [W-1:0] bus2;
  sync_state_t  st2;

  data_sync_src #(.DATA_WIDTH(W), .NUM_STAGES(2), .HOLD_CYCLES(H2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .unsync_bus(bus2), .bus_enable(en2), .ack_async(ack2),
    .busy(busy2), .done_pulse(done2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_rx  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {bus_enable, busy, in_ready, done_pulse, unsync_bus};
  endfunction

  // Destination: two-flop enable sync, capture on synced rising edge, ack = synced level.
  logic [2:0] en_s;
  always @(posedge dst_clk or posedge rst) begin
    if (rst) en_s <= '0;
    else     en_s <= {en_s[1:0], en2};
  end
  assign ack2 = en_s[1];

  always @(posedge dst_clk) begin
    if (!rst && en_s[1] && !en_s[2]) begin
      n_rx++;
      if (exp_q.size() == 0) check("e2e_extra_word", 32'(bus2), 32'hFFFF_FFFF);
      else                   check("e2e_word", 32'(bus2), 32'(exp_q.pop_front()));
    end
  end

`ifndef DATA_SYNC_SRC_ACK_EN
  // ---------------- open-loop driver ----------------
  typedef struct {
    logic [W-1:0] data;
    int           gap;
    bit           keep;
    int           en_hi;
    int           done_off;
  } vec_t;

  // Enters and leaves on a negedge; checks every cycle from acceptance to done_pulse.
  task automatic send_word(input logic [W-1:0] d, input bit keep, input int en_hi,
                           input int done_off, output int acc);
    int n;
    logic [11:0] e;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= done_off; c++) begin
      @(negedge clk);
      e = {(c <= en_hi), (c < done_off), (c == done_off), (c == done_off), d};
      check($sformatf("xfer_%02h_c%0d", d, c), 32'(obs()), 32'(e));
      if (!keep) begin
        if (c < done_off) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = W'($urandom);
        end else begin
          in_valid = 1'b0;
          in_data  = d;
        end
      end
    end
  endtask
`else
  // ---------------- ack-mode driver ----------------
  task automatic ack_xfer(input logic [W-1:0] d, input int delay,
                          output int rise_n, output int fall_n);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("ack_en_high", 32'(bus_enable), 32'd1);
    check("ack_bus", 32'(unsync_bus), 32'(d));
    repeat (delay - 1) @(negedge clk);
    ack_main = 1'b1;
    rise_n = 0;
    while (bus_enable && rise_n < 50) begin
      @(posedge clk);
      #1;
      rise_n++;
    end
    @(negedge clk);
    ack_main = 1'b0;
    fall_n = 0;
    while (!done_pulse && fall_n < 50) begin
      @(posedge clk);
      #1;
      fall_n++;
    end
    @(negedge clk);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    int acc, prev_acc, n;
    logic [W-1:0] prev_word, w;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs()), 32'd0);
    check("reset_state", 32'(st_main), 32'(ST_IDLE));
    rst = 1'b0;
    check("ready_low_at_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_first_edge", 32'(in_ready), 32'd1);

`ifndef DATA_SYNC_SRC_ACK_EN
    begin
      vec_t tbl[6];
      tbl[0] = '{8'hA5, 2, 1'b0, H, 2 * H + 1};
      tbl[1] = '{8'h01, 3, 1'b1, H, 2 * H + 1};
      tbl[2] = '{8'h02, 0, 1'b1, H, 2 * H + 1};
      tbl[3] = '{8'h03, 0, 1'b0, H, 2 * H + 1};
      tbl[4] = '{W'($urandom), $urandom_range(0, 3), 1'b0, H, 2 * H + 1};
      tbl[5] = '{W'($urandom), $urandom_range(0, 3), 1'b0, H, 2 * H + 1};
      prev_word = '0;
      prev_acc  = 0;
      for (int i = 0; i < 6; i++) begin
        for (int g = 0; g < tbl[i].gap; g++) begin
          @(negedge clk);
          check("idle_bus_hold", 32'(unsync_bus), 32'(prev_word));
          check("idle_ready", 32'(in_ready), 32'd1);
        end
        send_word(tbl[i].data, tbl[i].keep, tbl[i].en_hi, tbl[i].done_off, acc);
        if (i > 0 && tbl[i - 1].keep) check("b2b_spacing", 32'(acc - prev_acc), 32'(2 * H + 1));
        prev_acc  = acc;
        prev_word = tbl[i].data;
      end
    end

    // Reset in the middle of ASSERT
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_state", 32'(st_main), 32'(ST_ASSERT));
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'd0);
    check("async_reset_state", 32'(st_main), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    check("ready_low_after_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);
    send_word(8'h3C, 1'b0, H, 2 * H + 1, acc);
`else
    begin
      int r_n, f_n;
      ack_xfer(8'h5A, 3, r_n, f_n);
      check("ack_rise_to_en_fall", 32'(r_n), 32'd3);
      check("ack_fall_to_done", 32'(f_n), 32'd3);
      check("ack_done_ready", 32'(in_ready), 32'd1);
      check("ack_done_busy", 32'(busy), 32'd0);
      check("ack_bus_after", 32'(unsync_bus), 32'h5A);

      // Acknowledge never arrives: the transfer must stall in ASSERT.
      in_data  = 8'h66;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("stuck_state", 32'(st_main), 32'(ST_ASSERT));
      check("stuck_ready", 32'(in_ready), 32'd0);
      check("stuck_enable", 32'(bus_enable), 32'd1);

      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", 32'(obs()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("ready_low_after_reset", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_reset", 32'(in_ready), 32'd1);
      ack_xfer(8'h3C, 2, r_n, f_n);
      check("post_reset_rise", 32'(r_n), 32'd3);
      check("post_reset_fall", 32'(f_n), 32'd3);
      check("post_reset_bus", 32'(unsync_bus), 32'h3C);
    end
`endif

    // ---------------- end-to-end through the destination model ----------------
    n_rx = 0;
    for (int i = 0; i < 16; i++) begin
      w = W'($urandom);
      exp_q.push_back(w);
      in_data2  = w;
      in_valid2 = 1'b1;
      n = 0;
      while (!in_ready2 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready2) check("e2e_accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid2 = 1'b0;
      in_data2  = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n = 0;
    while ((busy2 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("e2e_word_count", 32'(n_rx), 32'd16);
    check("e2e_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
